// File: rtl/poci_readout_sequencer_if.sv
// Command/mux/pad signal bundle for the POCI readout sequencer.
// The command decoder (plus the byte mux) is the master side; the sequencer is the slave side.
interface poci_readout_sequencer_if #(
   parameter int CNT_W = 6
);
   logic             start;
   logic [7:0]       start_addr;
   logic [CNT_W-1:0] num_bytes;
   logic [7:0]       mux_msg;
   logic [7:0]       mux_addr;
   logic             serial_out;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output start, start_addr, num_bytes, mux_msg,
      input  mux_addr, serial_out, busy, done, err
   );

   modport slave (
      input  start, start_addr, num_bytes, mux_msg,
      output mux_addr, serial_out, busy, done, err
   );
endinterface

// File: rtl/poci_readout_sequencer.sv
// POCI readout sequencer: walks the byte mux from a start address and
// streams the selected bytes LSB-first as one gapless serial stream.
//
// state | meaning
// IDLE  | outputs parked at 0, waiting for a valid start request
// LOAD  | first mux address presented, first byte settling on mux_msg
// SHIFT | bits leaving on serial_out; next byte fetched during bit 7
module poci_readout_sequencer #(
   parameter int MAX_ADDR = 59,
   parameter int CNT_W    = 6
) (
   input logic                     sclk,
   input logic                     rst,
   poci_readout_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [7:0]       mux_addr_q, mux_addr_d;
   logic             ser_q, ser_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [7:0]       shreg_q, shreg_d;

   logic [8:0]       last_addr;
   logic             req_ok;
   logic             more_bytes;

   // Last address touched by the request; 9 bits so an oversized request cannot wrap into range.
   always_comb begin
      last_addr  = {1'b0, bus.start_addr} + 9'(bus.num_bytes) - 9'd1;
      req_ok     = (bus.start_addr != 8'd0) && (bus.num_bytes != '0) &&
                   (last_addr <= 9'(MAX_ADDR));
      more_bytes = (byte_cnt_q > CNT_W'(1));
   end

   // Register all sequencer state; rst parks every output at 0 without a clock edge.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mux_addr_q <= 8'd0;
         ser_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         byte_cnt_q <= '0;
         bit_cnt_q  <= 3'd0;
         shreg_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         mux_addr_q <= mux_addr_d;
         ser_q      <= ser_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         byte_cnt_q <= byte_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shreg_q    <= shreg_d;
      end
   end

   // Next-state and next-output logic; done is a single-cycle pulse by default.
   always_comb begin
      state_d    = state_q;
      mux_addr_d = mux_addr_q;
      ser_d      = ser_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = err_q;
      byte_cnt_d = byte_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;

      case (state_q)
         IDLE: begin
            mux_addr_d = 8'd0;
            ser_d      = 1'b0;
            busy_d     = 1'b0;
            if (bus.start) begin
               if (req_ok) begin
                  mux_addr_d = bus.start_addr;
                  byte_cnt_d = bus.num_bytes;
                  err_d      = 1'b0;
                  busy_d     = 1'b1;
                  state_d    = LOAD;
               end else begin
                  err_d = 1'b1;
               end
            end
         end

         LOAD: begin
            shreg_d   = {1'b0, bus.mux_msg[7:1]};
            ser_d     = bus.mux_msg[0];
            bit_cnt_d = 3'd0;
            state_d   = SHIFT;
         end

         SHIFT: begin
            if (bit_cnt_q == 3'd7) begin
               if (more_bytes) begin
                  // mux_addr already moved on during bit 7, so mux_msg holds the next byte.
                  shreg_d    = {1'b0, bus.mux_msg[7:1]};
                  ser_d      = bus.mux_msg[0];
                  byte_cnt_d = byte_cnt_q - CNT_W'(1);
                  bit_cnt_d  = 3'd0;
               end else begin
                  state_d    = IDLE;
                  done_d     = 1'b1;
                  busy_d     = 1'b0;
                  ser_d      = 1'b0;
                  mux_addr_d = 8'd0;
                  byte_cnt_d = '0;
                  bit_cnt_d  = 3'd0;
                  shreg_d    = 8'd0;
               end
            end else begin
               ser_d     = shreg_q[0];
               shreg_d   = {1'b0, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd6 && more_bytes) begin
                  mux_addr_d = mux_addr_q + 8'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign bus.mux_addr   = mux_addr_q;
   assign bus.serial_out = ser_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule
